// File: rtl/div_pkg.sv
// Shared encodings for the sequential divider: op codes, FSM states, conditional negate helper.
// Pure declarations; no timing or flow control of its own.
package div_pkg;

    localparam int DIV_MAXW = 64;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } div_state_e;

    // Two's-complement negate when neg is set; callers zero-extend and truncate to their width.
    function automatic logic [DIV_MAXW-1:0] cond_neg(input logic [DIV_MAXW-1:0] x, input logic neg);
        return neg ? (~x + DIV_MAXW'(1)) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract divisor if it fits.
// Combinational, no flow control.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // One extra bit each so the shifted remainder and the borrow never truncate.
    assign shifted  = {rem, msb};
    assign trial    = {1'b0, shifted} - {2'b00, divisor};
    assign q_bit    = ~trial[WIDTH+1];
    assign next_rem = q_bit ? WIDTH'(trial) : WIDTH'(shifted);

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned divide and remainder; start-to-done WIDTH+2 cycles (2 for b==0 or MIN/-1 when SEQ_DIVIDER_EARLY_OUT_EN is defined).
// Accepts start in IDLE or in the DONE cycle (back-to-back); start while busy is ignored.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dbz
);

    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    div_state_e    state;
    div_op_e       op_q;
    logic [CW-1:0] cnt;
    logic [W-1:0]  quo;
    logic [W-1:0]  rem;
    logic [W-1:0]  div_q;
    logic [W-1:0]  a_raw;
    logic          sa_q;
    logic          sb_q;
    logic          dbz_q;
    logic          ovf_q;

    logic          signed_in;
    logic          dbz_in;
    logic          ovf_in;
    logic          early_out;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;

    assign signed_in = (op[0] == 1'b0);
    assign dbz_in    = (b == '0);
    assign ovf_in    = signed_in && (a == MIN_VAL) && (b == '1);
    assign a_mag     = W'(cond_neg(DIV_MAXW'(a), signed_in & a[W-1]));
    assign b_mag     = W'(cond_neg(DIV_MAXW'(b), signed_in & b[W-1]));

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    assign early_out = dbz_in | ovf_in;
`else
    assign early_out = 1'b0;
`endif

    logic [W-1:0] next_rem;
    logic         q_bit;

    div_step #(.WIDTH(W)) u_step (
        .rem      (rem),
        .msb      (quo[W-1]),
        .divisor  (div_q),
        .next_rem (next_rem),
        .q_bit    (q_bit)
    );

    logic         signed_q;
    logic         is_rem;
    logic [W-1:0] q_sgn;
    logic [W-1:0] r_sgn;
    logic [W-1:0] q_res;
    logic [W-1:0] r_res;
    logic [W-1:0] fix_result;

    assign signed_q = (op_q == DIV_OP_DIV) || (op_q == DIV_OP_REM);
    assign is_rem   = (op_q == DIV_OP_REM) || (op_q == DIV_OP_REMU);
    assign q_sgn    = W'(cond_neg(DIV_MAXW'(quo), signed_q & (sa_q ^ sb_q)));
    assign r_sgn    = W'(cond_neg(DIV_MAXW'(rem), signed_q & sa_q));

    // Special cases are forced here so the early-out path never depends on CALC having run.
    always_comb begin
        q_res = q_sgn;
        r_res = r_sgn;
        if (dbz_q) begin
            q_res = '1;
            r_res = a_raw;
        end else if (ovf_q) begin
            q_res = MIN_VAL;
            r_res = '0;
        end
        fix_result = is_rem ? r_res : q_res;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            op_q   <= DIV_OP_DIV;
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            div_q  <= '0;
            a_raw  <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            dbz    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q  <= div_op_e'(op);
                        quo   <= a_mag;
                        rem   <= '0;
                        div_q <= b_mag;
                        a_raw <= a;
                        sa_q  <= a[W-1];
                        sb_q  <= b[W-1];
                        dbz_q <= dbz_in;
                        ovf_q <= ovf_in;
                        cnt   <= CW'(W-1);
                        busy  <= 1'b1;
                        state <= early_out ? ST_FIX : ST_CALC;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    // Dividend shifts out the top while quotient bits fill in from the bottom.
                    quo <= {quo[W-2:0], q_bit};
                    rem <= next_rem;
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_FIX: begin
                    result <= fix_result;
                    dbz    <= dbz_q;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
